multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style main control FSM with a memory-stall timeout watchdog.
// Define JUMP_INSN_EN to enable the J instruction (op 000010); otherwise that opcode is illegal.
module multicycle_control #(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic [1:0] ALUOp,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic       illegal_op,
    output logic       mem_err,
    output logic [3:0] state
);

    localparam int unsigned CW = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
    localparam logic [CW-1:0] WAIT_LIMIT = CW'(MEM_WAIT_MAX);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RCOMP  = 4'd7,
`ifdef JUMP_INSN_EN
        BRANCH = 4'd8,
        JUMP   = 4'd9
`else
        BRANCH = 4'd8
`endif
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_wait;
    logic          r_illegal;
    logic          r_mem_err;
    logic          w_stall;
    logic          w_timeout;

    assign w_stall    = !mem_ready && (r_state == FETCH || r_state == MEMRD || r_state == MEMWR);
    assign w_timeout  = w_stall && (r_wait == WAIT_LIMIT);
    assign state      = r_state;
    assign illegal_op = r_illegal;
    assign mem_err    = r_mem_err;

    // Wait counter defaults to clear; it only survives a cycle that stalls in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= FETCH;
            r_wait    <= '0;
            r_illegal <= 1'b0;
            r_mem_err <= 1'b0;
        end else begin
            r_wait    <= '0;
            r_illegal <= 1'b0;
            r_mem_err <= 1'b0;
            if (w_timeout) begin
                r_state   <= FETCH;
                r_mem_err <= 1'b1;
            end else if (w_stall) begin
                r_wait <= r_wait + CW'(1);
            end else begin
                case (r_state)
                    FETCH:  r_state <= DECODE;
                    DECODE: begin
                        case (op)
                            6'b100011,
                            6'b101011: r_state <= MEMADR;
                            6'b000000: r_state <= EXEC;
                            6'b000100: r_state <= BRANCH;
`ifdef JUMP_INSN_EN
                            6'b000010: r_state <= JUMP;
`endif
                            default: begin
                                r_state   <= FETCH;
                                r_illegal <= 1'b1;
                            end
                        endcase
                    end
                    MEMADR: r_state <= (op == 6'b100011) ? MEMRD : MEMWR;
                    MEMRD:  r_state <= MEMWB;
                    MEMWR:  r_state <= FETCH;
                    EXEC:   r_state <= RCOMP;
                    default: r_state <= FETCH;
                endcase
            end
        end
    end

    always_comb begin
        ALUOp       = 2'b00;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        case (r_state)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            DECODE: ALUSrcB = 2'b11;
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            RCOMP: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
`ifdef JUMP_INSN_EN
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
`endif
            default: ;
        endcase
    end

endmodule
